pc_sequencer: RTL and testbench

Parametrised IF-stage program-counter unit. Successor to the combinational next-PC mux: owns the PC register and a halt state machine, and adds a small return-address stack (RAS) for call and return. Sits at the head of the IF stage. Its outputs are PC (fetch address) and PCPlusOne (forwarded down the pipe). Redirect requests come from the ID stage (jump, call, return) and from EX/WB (branch, overwrite).

---
 rtl/pc_pkg.sv | 19 +
 rtl/return_addr_stack.sv | 67 ++++++
 rtl/pc_sequencer.sv | 123 ++++++++++++
 tb/tb_pc_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer and its return-address stack.
package pc_pkg;

  // Halt FSM encoding
  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_e;

  // Default RAS depth and the matching pointer width
  localparam int unsigned STACK_DEPTH = 4;
  localparam int unsigned PTR_W       = $clog2(STACK_DEPTH);

  // Pointer width for an arbitrary depth; a depth of one still needs one bit
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular LIFO of return addresses. A push into a full stack overwrites the
// oldest entry, so the most recent StackDepth calls are always retained.
module return_addr_stack
  import pc_pkg::*;
#(
  parameter int unsigned DataWidth  = 16,
  parameter int unsigned StackDepth = STACK_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DataWidth-1:0] push_data,
  output logic [DataWidth-1:0] top,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned PtrW = ptr_width(StackDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(StackDepth);

  logic [DataWidth-1:0] mem [StackDepth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      top_ptr;
  logic [CntW-1:0]      count;

  // wr_ptr always names the next free slot; it wraps because depth is a power of two
  assign top_ptr = wr_ptr - PtrW'(1);
  assign top     = mem[top_ptr];
  assign empty   = (count == '0);
  assign full    = (count == DepthC);

  // Pointer, occupancy and sticky error flags; pop is given precedence if both arrive
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (pop) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr - PtrW'(1);
        count  <= count - CntW'(1);
      end
    end else if (push) begin
      wr_ptr <= wr_ptr + PtrW'(1);
      if (full) begin
        overflow <= 1'b1;
      end else begin
        count <= count + CntW'(1);
      end
    end
  end

  // Entry storage; reset only clears occupancy, stale data is never visible
  always_ff @(posedge clk) begin
    if (!reset && push && !pop) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage program counter: owns the PC register, the RUN/HALTED state machine
// and the return-address stack used by call/return redirects.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_RUN    | PC advances or redirects according to request priority
//   ST_HALTED | PC frozen; only PCOverwrite or Resume have any effect
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned DataWidth   = 16,
  parameter int unsigned ResetVector = 0,
  parameter int unsigned Increment   = 1,
  parameter int unsigned StackDepth  = STACK_DEPTH
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 Halt,
  input  logic                 Resume,
  input  logic                 TakeBranch,
  input  logic [DataWidth-1:0] BranchTarget,
  input  logic                 TakeJump,
  input  logic                 Call,
  input  logic [DataWidth-1:0] JumpTarget,
  input  logic                 Return,
  input  logic                 PCOverwrite,
  input  logic [DataWidth-1:0] OverwriteAddress,
  output logic [DataWidth-1:0] PC,
  output logic [DataWidth-1:0] PCPlusOne,
  output logic                 Halted,
  output logic                 StackEmpty,
  output logic                 StackFull,
  output logic                 StackOverflow,
  output logic                 StackUnderflow
);

  localparam logic [DataWidth-1:0] ResetPc = DataWidth'(ResetVector);
  localparam logic [DataWidth-1:0] IncStep = DataWidth'(Increment);

  pc_state_e            state, state_next;
  logic [DataWidth-1:0] pc_next;
  logic                 ras_push;
  logic                 ras_pop;
  logic [DataWidth-1:0] ras_top;

  return_addr_stack #(
    .DataWidth (DataWidth),
    .StackDepth(StackDepth)
  ) u_ras (
    .clk      (Clk),
    .reset    (Reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(PCPlusOne),
    .top      (ras_top),
    .empty    (StackEmpty),
    .full     (StackFull),
    .overflow (StackOverflow),
    .underflow(StackUnderflow)
  );

  // State and PC register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_RUN;
      PC    <= ResetPc;
    end else begin
      state <= state_next;
      PC    <= pc_next;
    end
  end

  // Request arbitration: next state, next PC and the winning stack operation
  always_comb begin
    state_next = state;
    pc_next    = PC;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (PCOverwrite) begin
          pc_next = OverwriteAddress;
        end else if (TakeBranch) begin
          pc_next = BranchTarget;
        end else if (Stall) begin
          pc_next = PC;
        end else if (Return) begin
          // an empty stack holds PC; the pop still flags the underflow
          ras_pop = 1'b1;
          if (!StackEmpty) begin
            pc_next = ras_top;
          end
        end else if (TakeJump) begin
          pc_next  = JumpTarget;
          ras_push = Call;
        end else if (Halt) begin
          state_next = ST_HALTED;
        end else begin
          pc_next = PCPlusOne;
        end
      end
      ST_HALTED: begin
        if (PCOverwrite) begin
          state_next = ST_RUN;
          pc_next    = OverwriteAddress;
        end else if (Resume) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Outputs derived from the registered state
  always_comb begin
    PCPlusOne = PC + IncStep;
    Halted    = (state == ST_HALTED);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based model.
module tb_pc_sequencer;

  localparam int DW    = 8;
  localparam int MOD   = 256;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, stall, halt, resume;
  logic          take_branch, take_jump, call, ret, pc_overwrite;
  logic [DW-1:0] branch_target, jump_target, overwrite_address;
  logic [DW-1:0] pc, pc_plus_one;
  logic          halted, stack_empty, stack_full, stack_overflow, stack_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_pc;
  bit m_halt, m_ovf, m_udf;
  int m_ras[$];

  pc_sequencer #(
    .DataWidth  (DW),
    .ResetVector(0),
    .Increment  (1),
    .StackDepth (DEPTH)
  ) dut (
    .Clk             (clk),
    .Reset           (reset),
    .Stall           (stall),
    .Halt            (halt),
    .Resume          (resume),
    .TakeBranch      (take_branch),
    .BranchTarget    (branch_target),
    .TakeJump        (take_jump),
    .Call            (call),
    .JumpTarget      (jump_target),
    .Return          (ret),
    .PCOverwrite     (pc_overwrite),
    .OverwriteAddress(overwrite_address),
    .PC              (pc),
    .PCPlusOne       (pc_plus_one),
    .Halted          (halted),
    .StackEmpty      (stack_empty),
    .StackFull       (stack_full),
    .StackOverflow   (stack_overflow),
    .StackUnderflow  (stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; stall = 0; halt = 0; resume = 0;
    take_branch = 0; take_jump = 0; call = 0; ret = 0; pc_overwrite = 0;
  endtask

  // one clock edge of the specified behaviour, using the inputs as sampled
  task automatic model_step();
    if (reset) begin
      m_pc = 0; m_halt = 0; m_ovf = 0; m_udf = 0;
      m_ras.delete();
    end else if (m_halt) begin
      if (pc_overwrite) begin
        m_pc = int'(overwrite_address); m_halt = 0;
      end else if (resume) begin
        m_halt = 0;
      end
    end else if (pc_overwrite) m_pc = int'(overwrite_address);
    else if (take_branch) m_pc = int'(branch_target);
    else if (stall) m_pc = m_pc;
    else if (ret) begin
      if (m_ras.size() == 0) m_udf = 1;
      else m_pc = m_ras.pop_back();
    end else if (take_jump) begin
      if (call) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
        m_ras.push_back((m_pc + 1) % MOD);
      end
      m_pc = int'(jump_target);
    end else if (halt) m_halt = 1;
    else m_pc = (m_pc + 1) % MOD;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".pc_plus_one"}, 32'(pc_plus_one), 32'((m_pc + 1) % MOD));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
    chk({tag, ".empty"}, 32'(stack_empty), 32'(m_ras.size() == 0));
    chk({tag, ".full"}, 32'(stack_full), 32'(m_ras.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(stack_overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(stack_underflow), 32'(m_udf));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    idle();
    branch_target = '0; jump_target = '0; overwrite_address = '0;

    // reset state
    reset = 1; tick("reset");
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_empty", 32'(stack_empty), 32'd1);
    idle();

    // sequential stepping
    for (int i = 1; i <= 5; i++) begin
      tick("idle");
      chk("idle_pc", 32'(pc), 32'(i));
    end

    // call then return
    pc_overwrite = 1; overwrite_address = 8'd3; tick("ovw3"); idle();
    take_jump = 1; call = 1; jump_target = 8'd78; tick("call78"); idle();
    chk("call_pc", 32'(pc), 32'd78);
    tick("after_call");
    ret = 1; tick("ret4"); idle();
    chk("ret_pc", 32'(pc), 32'd4);
    chk("ret_empty", 32'(stack_empty), 32'd1);

    // overflow drops oldest, then drain into underflow
    pc_overwrite = 1; overwrite_address = 8'd10; tick("ovw10"); idle();
    for (int k = 0; k < 5; k++) begin
      take_jump = 1; call = 1; jump_target = 8'(20 + 10 * k);
      tick("call_chain");
    end
    idle();
    chk("ovf_flag", 32'(stack_overflow), 32'd1);
    for (int k = 0; k < 4; k++) begin
      ret = 1; tick("ret_chain");
      chk("ret_chain_pc", 32'(pc), 32'(51 - 10 * k));
    end
    tick("ret_empty");
    chk("udf_pc", 32'(pc), 32'd21);
    chk("udf_flag", 32'(stack_underflow), 32'd1);
    idle();

    // priority
    pc_overwrite = 1; overwrite_address = 8'd35; take_branch = 1; branch_target = 8'd10;
    take_jump = 1; jump_target = 8'd78; stall = 1;
    tick("prio_ovw");  chk("prio_ovw_pc", 32'(pc), 32'd35);
    pc_overwrite = 0; tick("prio_br"); chk("prio_br_pc", 32'(pc), 32'd10);
    take_branch = 0; tick("prio_stall"); chk("prio_stall_pc", 32'(pc), 32'd10);
    idle();

    // halt / resume / overwrite exit
    pc_overwrite = 1; overwrite_address = 8'd7; tick("ovw7"); idle();
    halt = 1; tick("halt"); idle();
    take_branch = 1; branch_target = 8'd10;
    for (int k = 0; k < 3; k++) begin
      tick("halted");
      chk("halted_pc", 32'(pc), 32'd7);
      chk("halted_flag", 32'(halted), 32'd1);
    end
    take_branch = 0; resume = 1; tick("resume"); idle();
    chk("resume_pc", 32'(pc), 32'd7);
    tick("resume_next"); chk("resume_next_pc", 32'(pc), 32'd8);
    halt = 1; tick("halt2"); idle();
    pc_overwrite = 1; resume = 1; overwrite_address = 8'd35; tick("halt_ovw"); idle();
    chk("halt_ovw_pc", 32'(pc), 32'd35);
    chk("halt_ovw_flag", 32'(halted), 32'd0);

    // width wrap and wrapped push
    pc_overwrite = 1; overwrite_address = 8'd255; tick("ovw255"); idle();
    tick("wrap"); chk("wrap_pc", 32'(pc), 32'd0);
    pc_overwrite = 1; overwrite_address = 8'd255; tick("ovw255b"); idle();
    take_jump = 1; call = 1; jump_target = 8'd5; tick("call_wrap"); idle();
    ret = 1; tick("ret_wrap"); idle();
    chk("ret_wrap_pc", 32'(pc), 32'd0);
    take_jump = 1; call = 1; jump_target = 8'd99; tick("call_pre_rst"); idle();
    reset = 1; tick("mid_reset"); idle();
    chk("mid_reset_empty", 32'(stack_empty), 32'd1);
    chk("mid_reset_ovf", 32'(stack_overflow), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset             = ($urandom_range(0, 199) == 0);
      pc_overwrite      = ($urandom_range(0, 99) < 4);
      take_branch       = ($urandom_range(0, 99) < 8);
      stall             = ($urandom_range(0, 99) < 10);
      ret               = ($urandom_range(0, 99) < 18);
      take_jump         = ($urandom_range(0, 99) < 25);
      call              = ($urandom_range(0, 99) < 60);
      halt              = ($urandom_range(0, 99) < 5);
      resume            = ($urandom_range(0, 99) < 20);
      branch_target     = 8'($urandom);
      jump_target       = 8'($urandom);
      overwrite_address = 8'($urandom);
      tick("rand");
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
